// File: rtl/countdown_timer.sv
// Multi-digit mixed-radix BCD countdown timer with tick prescaler, load/start/pause control and alarm.
// Optional build macro: COUNTDOWN_AUTORELOAD_EN (reload the clamped preset on expiry instead of stopping).
module countdown_timer #(
  parameter int NUM_DIGITS  = 4,
  parameter int SEXAGESIMAL = 1,
  parameter int CLK_DIV     = 10,
  parameter int DIV_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic                    start,
  input  logic                    pause,
  input  logic [4*NUM_DIGITS-1:0] preset,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    running,
  output logic                    tick,
  output logic                    done,
  output logic                    alarm
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLK_DIV - 1);
`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTORELOAD = 1'b1;
`else
  localparam bit AUTORELOAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   presc_q;
  logic [CW-1:0]          count_q;
  logic                   tick_q, done_q;
  logic                   tick_fire, dec_zero, reload_ok;
  logic [CW-1:0]          count_dec, preset_cl;

  // Odd-index digits are the tens-of-seconds / tens-of-minutes places in mm:ss mode.
  function automatic logic [3:0] digit_max(input int idx);
    if (SEXAGESIMAL != 0 && (idx % 2) == 1) return 4'd5;
    return 4'd9;
  endfunction

  function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] dec_bcd(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = digit_max(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // A tick only happens when no strobe overrides it on the same edge.
  assign tick_fire = (state_q == S_RUN) && !load && !pause && (presc_q == DIV_LAST);
  assign count_dec = dec_bcd(count_q);
  assign dec_zero  = (count_dec == '0);
  assign preset_cl = clamp_bcd(preset);
  assign reload_ok = AUTORELOAD && (preset_cl != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = S_IDLE;
    end else if (pause) begin
      if (state_q == S_RUN) state_d = S_PAUSED;
    end else if (start && (state_q == S_IDLE || state_q == S_PAUSED) && count_q != '0) begin
      state_d = S_RUN;
    end else if (tick_fire && dec_zero && !reload_ok) begin
      state_d = S_EXPIRED;
    end
  end

  always_comb begin
    running = (state_q == S_RUN);
    alarm   = (state_q == S_EXPIRED);
  end

  // Prescaler holds its value outside RUN so a pause keeps the partial tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      tick_q <= tick_fire;
      done_q <= tick_fire && dec_zero;
      if (load) begin
        presc_q <= '0;
        count_q <= preset_cl;
      end else if (tick_fire) begin
        presc_q <= '0;
        count_q <= (dec_zero && reload_ok) ? preset_cl : count_dec;
      end else if (state_q == S_RUN && !pause) begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at the default mm:ss, CLK_DIV=10 configuration.
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load, start, pause;
  logic [15:0] preset;
  logic [15:0] count;
  logic        running, tick, done, alarm;
  int          total = 0;
  int          bad   = 0;

  countdown_timer #(
    .NUM_DIGITS (4),
    .SEXAGESIMAL(1),
    .CLK_DIV    (10),
    .DIV_WIDTH  (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .start  (start),
    .pause  (pause),
    .preset (preset),
    .count  (count),
    .running(running),
    .tick   (tick),
    .done   (done),
    .alarm  (alarm)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_load(input logic [15:0] v);
    preset = v;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic strobe_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load = 1'b0; start = 1'b0; pause = 1'b0; preset = 16'h0000;
    #3;
    total++; if (count !== 16'h0000) begin bad++; $display("FAIL reset_count got=%h exp=0000", count); end
    total++; if ({running, tick, done, alarm} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {running, tick, done, alarm}); end
    step(); step();
    reset_n = 1'b1;
    step();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_idle running got=%b exp=0", running); end
  endtask

  task automatic test_clamp_zero_start();
    strobe_load(16'h0A7C);
    total++; if (count !== 16'h0959) begin bad++; $display("FAIL clamp got=%h exp=0959", count); end
    strobe_load(16'h0000);
    strobe_start();
    total++; if (running !== 1'b0) begin bad++; $display("FAIL zero_start running got=%b exp=0", running); end
    step();
    total++; if (count !== 16'h0000 || tick !== 1'b0) begin bad++; $display("FAIL zero_start count/tick got=%h/%b exp=0000/0", count, tick); end
  endtask

  task automatic test_basic();
    strobe_load(16'h0100);
    strobe_start();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL basic_running got=%b exp=1", running); end
    repeat (9) step();
    total++; if (count !== 16'h0100 || tick !== 1'b0) begin bad++; $display("FAIL basic_pre_tick got=%h/%b exp=0100/0", count, tick); end
    step();
    total++; if (count !== 16'h0059 || tick !== 1'b1) begin bad++; $display("FAIL basic_first_tick got=%h/%b exp=0059/1", count, tick); end
    step();
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL basic_tick_pulse got=%b exp=0", tick); end
    for (int k = 2; k <= 60; k++) begin
      repeat (8) step();
      step();
      total++; if (tick !== 1'b1) begin bad++; $display("FAIL basic_tick_%0d got=%b exp=1", k, tick); end
      if (k == 30) begin
        total++; if (count !== 16'h0030) begin bad++; $display("FAIL basic_half got=%h exp=0030", count); end
      end
      if (k < 60) step();
    end
`ifdef COUNTDOWN_AUTORELOAD_EN
    total++; if (count !== 16'h0100 || done !== 1'b1 || alarm !== 1'b0 || running !== 1'b1) begin bad++; $display("FAIL basic_reload got=%h d=%b a=%b r=%b exp=0100 1 0 1", count, done, alarm, running); end
`else
    total++; if (count !== 16'h0000 || done !== 1'b1 || alarm !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL basic_expire got=%h d=%b a=%b r=%b exp=0000 1 1 0", count, done, alarm, running); end
    step();
    total++; if (done !== 1'b0 || alarm !== 1'b1 || tick !== 1'b0) begin bad++; $display("FAIL basic_after got d=%b a=%b t=%b exp=0 1 0", done, alarm, tick); end
    strobe_start();
    total++; if (running !== 1'b0 || alarm !== 1'b1 || count !== 16'h0000) begin bad++; $display("FAIL expired_start got r=%b a=%b c=%h exp=0 1 0000", running, alarm, count); end
`endif
    strobe_load(16'h0100);
    total++; if (alarm !== 1'b0 || count !== 16'h0100 || running !== 1'b0) begin bad++; $display("FAIL load_clears got a=%b c=%h r=%b exp=0 0100 0", alarm, count, running); end
  endtask

  task automatic test_pause_resume();
    logic seen;
    strobe_load(16'h0100);
    strobe_start();
    repeat (10) step();
    total++; if (tick !== 1'b1 || count !== 16'h0059) begin bad++; $display("FAIL pause_tick got=%b/%h exp=1/0059", tick, count); end
    repeat (3) step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running got=%b exp=0", running); end
    seen = 1'b0;
    repeat (50) begin step(); if (tick !== 1'b0) seen = 1'b1; end
    total++; if (seen !== 1'b0 || count !== 16'h0059) begin bad++; $display("FAIL pause_hold got tick_seen=%b c=%h exp=0 0059", seen, count); end
    strobe_start();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL resume_running got=%b exp=1", running); end
    seen = 1'b0;
    repeat (6) begin step(); if (tick !== 1'b0) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL resume_early got tick_seen=%b exp=0", seen); end
    step();
    total++; if (tick !== 1'b1 || count !== 16'h0058) begin bad++; $display("FAIL resume_tick got=%b/%h exp=1/0058", tick, count); end
  endtask

  task automatic test_collision();
    strobe_load(16'h0100);
    strobe_start();
    repeat (9) step();
    preset = 16'h0245; load = 1'b1; start = 1'b1;
    step();
    load = 1'b0; start = 1'b0;
    total++; if (count !== 16'h0245 || running !== 1'b0 || tick !== 1'b0) begin bad++; $display("FAIL load_on_tick got c=%h r=%b t=%b exp=0245 0 0", count, running, tick); end
    strobe_start();
    repeat (9) step();
    pause = 1'b1; start = 1'b1;
    step();
    pause = 1'b0; start = 1'b0;
    total++; if (running !== 1'b0 || tick !== 1'b0 || count !== 16'h0245) begin bad++; $display("FAIL pause_on_tick got r=%b t=%b c=%h exp=0 0 0245", running, tick, count); end
    strobe_start();
    total++; if (running !== 1'b1 || tick !== 1'b0) begin bad++; $display("FAIL resume_edge got r=%b t=%b exp=1 0", running, tick); end
    step();
    total++; if (tick !== 1'b1 || count !== 16'h0244) begin bad++; $display("FAIL resume_first got t=%b c=%h exp=1 0244", tick, count); end
  endtask

  task automatic test_async_reset();
    strobe_load(16'h0042);
    strobe_start();
    repeat (3) step();
    total++; if (running !== 1'b1 || count !== 16'h0042) begin bad++; $display("FAIL prereset got r=%b c=%h exp=1 0042", running, count); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (count !== 16'h0000 || running !== 1'b0 || alarm !== 1'b0) begin bad++; $display("FAIL async_reset got c=%h r=%b a=%b exp=0000 0 0", count, running, alarm); end
    reset_n = 1'b1;
    step();
  endtask

`ifdef COUNTDOWN_AUTORELOAD_EN
  task automatic test_autoreload();
    strobe_load(16'h0003);
    strobe_start();
    repeat (10) step();
    total++; if (count !== 16'h0002) begin bad++; $display("FAIL ar_2 got=%h exp=0002", count); end
    repeat (10) step();
    total++; if (count !== 16'h0001) begin bad++; $display("FAIL ar_1 got=%h exp=0001", count); end
    repeat (10) step();
    total++; if (count !== 16'h0003 || done !== 1'b1 || running !== 1'b1 || alarm !== 1'b0) begin bad++; $display("FAIL ar_reload got c=%h d=%b r=%b a=%b exp=0003 1 1 0", count, done, running, alarm); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ar_done_pulse got=%b exp=0", done); end
    repeat (29) step();
    total++; if (count !== 16'h0003 || done !== 1'b1 || alarm !== 1'b0) begin bad++; $display("FAIL ar_second got c=%h d=%b a=%b exp=0003 1 0", count, done, alarm); end
  endtask
`endif

  initial begin
    test_reset();
    test_clamp_zero_start();
    test_basic();
    test_pause_resume();
    test_collision();
    test_async_reset();
`ifdef COUNTDOWN_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
